// File: rtl/stack_pkg.sv
// Shared types and defaults for the stack access controller.
package stack_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 10;

    localparam logic [DEF_ADDR_W-1:0] SP_RESET_VAL = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_WR = 2'd1,
        POP_RD  = 2'd2,
        POP_CAP = 2'd3
    } stack_state_t;

endpackage

// File: rtl/stack_access_ctrl_occupancy.sv
// Stack occupancy counter: up/down count with clear, registered FULL/EMPTY flags.
module stack_occupancy
    import stack_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = 256
) (
    input  logic CLK,
    input  logic RST,
    input  logic INC,
    input  logic DEC,
    input  logic CLR,
    output logic FULL,
    output logic EMPTY
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a clear overrides any in-flight increment or decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (INC && !DEC) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (DEC && !INC) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count and flags register together so the flags always match the count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            FULL  <= 1'b0;
            EMPTY <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            FULL  <= (cnt_d == CNT_W'(DEPTH));
            EMPTY <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/stack_access_ctrl.sv
// Sequences PUSH/POP micro-operations between control, stack pointer and scratch RAM.
module stack_access_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PUSH,
    input  logic              POP,
    input  logic [DATA_W-1:0] PUSH_DATA,
    input  logic [ADDR_W-1:0] SP_IN,
    input  logic              SP_LD,
    input  logic [DATA_W-1:0] SCR_RDATA,
    output logic [ADDR_W-1:0] SCR_ADDR,
    output logic [DATA_W-1:0] SCR_WDATA,
    output logic              SCR_WE,
    output logic              SP_INCR,
    output logic              SP_DECR,
    output logic [DATA_W-1:0] POP_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              FULL,
    output logic              EMPTY
);

    localparam logic [1:0] S_IDLE    = 2'(IDLE);
    localparam logic [1:0] S_PUSH_WR = 2'(PUSH_WR);
    localparam logic [1:0] S_POP_RD  = 2'(POP_RD);
    localparam logic [1:0] S_POP_CAP = 2'(POP_CAP);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [DATA_W-1:0] push_word_q;
    logic [DATA_W-1:0] pop_data_q;
    logic              done_q;
    logic              err_q;

    logic we_c;
    logic incr_c;
    logic decr_c;
    logic accept_push_c;
    logic reject_c;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore decode of RAM/SP controls; requests only looked at in IDLE.
    always_comb begin
        state_d       = state_q;
        SCR_ADDR      = SP_IN;
        SCR_WDATA     = push_word_q;
        we_c          = 1'b0;
        incr_c        = 1'b0;
        decr_c        = 1'b0;
        BUSY          = 1'b1;
        accept_push_c = 1'b0;
        reject_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                BUSY = 1'b0;
                if (PUSH && POP) begin
                    reject_c = 1'b1;
                end else if (PUSH) begin
                    if (FULL) begin
                        reject_c = 1'b1;
                    end else begin
                        accept_push_c = 1'b1;
                        state_d       = S_PUSH_WR;
                    end
                end else if (POP) begin
                    if (EMPTY) begin
                        reject_c = 1'b1;
                    end else begin
                        state_d = S_POP_RD;
                    end
                end
            end
            S_PUSH_WR: begin
                SCR_ADDR = SP_IN - ADDR_W'(1);
                we_c     = 1'b1;
                decr_c   = 1'b1;
                state_d  = S_IDLE;
            end
            S_POP_RD: begin
                state_d = S_POP_CAP;
            end
            S_POP_CAP: begin
                incr_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A reset arriving mid-operation suppresses the write and SP strobes of that cycle.
    assign SCR_WE  = we_c   && !RST;
    assign SP_INCR = incr_c && !RST;
    assign SP_DECR = decr_c && !RST;

    // Registered status pulses, push latch and popped-word holding register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            push_word_q <= '0;
            pop_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= (state_q == S_PUSH_WR) || (state_q == S_POP_CAP);
            err_q  <= reject_c;
            if (accept_push_c) begin
                push_word_q <= PUSH_DATA;
            end
            if (state_q == S_POP_CAP) begin
                pop_data_q <= SCR_RDATA;
            end
        end
    end

    assign POP_DATA = pop_data_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

    // Occupancy tracking; an SP load empties the stack.
    stack_occupancy #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_occupancy (
        .CLK   (CLK),
        .RST   (RST),
        .INC   (state_q == S_PUSH_WR),
        .DEC   (state_q == S_POP_CAP),
        .CLR   (SP_LD),
        .FULL  (FULL),
        .EMPTY (EMPTY)
    );

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Bench for stack_access_ctrl: SP/RAM environment, transaction-timeline model, directed + random stimulus.
module tb_stack_access_ctrl;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 10;
    localparam int          DEP = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          PUSH;
    logic          POP;
    logic [DW-1:0] PUSH_DATA;
    logic [AW-1:0] SP_IN;
    logic          SP_LD;
    logic [DW-1:0] SCR_RDATA;
    logic [AW-1:0] SCR_ADDR;
    logic [DW-1:0] SCR_WDATA;
    logic          SCR_WE;
    logic          SP_INCR;
    logic          SP_DECR;
    logic [DW-1:0] POP_DATA;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic          FULL;
    logic          EMPTY;

    logic [AW-1:0] ld_val;
    logic [AW-1:0] sp = '0;
    logic [DW-1:0] ram [256];

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: op_kind 0 none, 1 push, 2 pop; age counts cycles since accept.
    int            occ;
    int            op_kind;
    int            age;
    logic [DW-1:0] m_lat;
    logic [DW-1:0] m_cap;
    logic [DW-1:0] m_pop;
    bit            m_done;
    bit            m_err;

    always #5 CLK = ~CLK;

    stack_access_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEP)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PUSH      (PUSH),
        .POP       (POP),
        .PUSH_DATA (PUSH_DATA),
        .SP_IN     (SP_IN),
        .SP_LD     (SP_LD),
        .SCR_RDATA (SCR_RDATA),
        .SCR_ADDR  (SCR_ADDR),
        .SCR_WDATA (SCR_WDATA),
        .SCR_WE    (SCR_WE),
        .SP_INCR   (SP_INCR),
        .SP_DECR   (SP_DECR),
        .POP_DATA  (POP_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .FULL      (FULL),
        .EMPTY     (EMPTY)
    );

    // Environment: stack pointer register and synchronous scratch RAM.
    always @(posedge CLK) begin
        if (SCR_WE) ram[SCR_ADDR] <= SCR_WDATA;
        SCR_RDATA <= ram[SCR_ADDR];
        if (SP_LD)        sp <= ld_val;
        else if (SP_INCR) sp <= sp + 8'd1;
        else if (SP_DECR) sp <= sp - 8'd1;
    end
    assign SP_IN = sp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs for the current cycle, derived from the active transaction.
    task automatic model_compare();
        bit            push_act;
        bit            pop_act;
        logic [AW-1:0] ea;
        push_act = (op_kind == 1);
        pop_act  = (op_kind == 2);
        ea       = push_act ? sp - 8'd1 : sp;
        chk("busy",     32'(BUSY),     32'(op_kind != 0));
        chk("scr_we",   32'(SCR_WE),   32'(push_act));
        chk("sp_decr",  32'(SP_DECR),  32'(push_act));
        chk("sp_incr",  32'(SP_INCR),  32'(pop_act && age == 2));
        chk("scr_addr", 32'(SCR_ADDR), 32'(ea));
        if (push_act) chk("scr_wdata", 32'(SCR_WDATA), 32'(m_lat));
        chk("done",     32'(DONE),     32'(m_done));
        chk("err",      32'(ERR),      32'(m_err));
        chk("pop_data", 32'(POP_DATA), 32'(m_pop));
        chk("full",     32'(FULL),     32'(occ == DEP));
        chk("empty",    32'(EMPTY),    32'(occ == 0));
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic model_step();
        bit nd;
        bit ne;
        int nocc;
        if (RST) begin
            occ = 0; op_kind = 0; age = 0;
            m_lat = '0; m_pop = '0; m_done = 1'b0; m_err = 1'b0;
            return;
        end
        nd   = (op_kind == 1) || (op_kind == 2 && age == 2);
        ne   = 1'b0;
        nocc = occ;
        if (op_kind == 1) nocc = nocc + 1;
        if (op_kind == 2 && age == 2) nocc = nocc - 1;
        if (op_kind == 2 && age == 1) m_cap = ram[sp];
        if (op_kind == 2 && age == 2) m_pop = m_cap;
        if (op_kind == 0) begin
            if (PUSH && POP) ne = 1'b1;
            else if (PUSH) begin
                if (occ == DEP) ne = 1'b1;
                else begin m_lat = PUSH_DATA; op_kind = 1; age = 1; end
            end else if (POP) begin
                if (occ == 0) ne = 1'b1;
                else begin op_kind = 2; age = 1; end
            end
        end else if (op_kind == 2 && age == 1) begin
            age = 2;
        end else begin
            op_kind = 0; age = 0;
        end
        if (SP_LD) nocc = 0;
        occ    = nocc;
        m_done = nd;
        m_err  = ne;
    endtask

    // Apply one cycle of inputs, then check the following cycle against the model.
    task automatic tick(input bit r, input bit p, input bit q, input logic [DW-1:0] d,
                        input bit l, input logic [AW-1:0] lv);
        RST = r; PUSH = p; POP = q; PUSH_DATA = d; SP_LD = l; ld_val = lv;
        model_step();
        @(negedge CLK);
        model_compare();
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        occ = 0; op_kind = 0; age = 0;
        m_lat = '0; m_cap = '0; m_pop = '0; m_done = 1'b0; m_err = 1'b0;

        // Reset values.
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("rst_busy",  32'(BUSY),     32'd0);
        chk("rst_empty", 32'(EMPTY),    32'd1);
        chk("rst_full",  32'(FULL),     32'd0);
        chk("rst_pop",   32'(POP_DATA), 32'd0);

        // Push at SP=0 wraps the address to 0xFF.
        tick(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 10'h2A5, 1'b0, '0);
        chk("push_addr",  32'(SCR_ADDR),  32'h0FF);
        chk("push_we",    32'(SCR_WE),    32'd1);
        chk("push_wdata", 32'(SCR_WDATA), 32'h2A5);
        chk("push_decr",  32'(SP_DECR),   32'd1);
        idle();
        chk("push_done",  32'(DONE),  32'd1);
        chk("push_empty", 32'(EMPTY), 32'd0);

        // Pop the word back from 0xFF.
        tick(1'b0, 1'b0, 1'b1, '0, 1'b0, '0);
        chk("poprd_addr", 32'(SCR_ADDR), 32'h0FF);
        chk("poprd_incr", 32'(SP_INCR),  32'd0);
        idle();
        chk("popcap_addr", 32'(SCR_ADDR), 32'h0FF);
        chk("popcap_incr", 32'(SP_INCR),  32'd1);
        idle();
        chk("pop_done",  32'(DONE),     32'd1);
        chk("pop_data",  32'(POP_DATA), 32'h2A5);
        chk("pop_empty", 32'(EMPTY),    32'd1);

        // Pop on empty is rejected.
        tick(1'b0, 1'b0, 1'b1, '0, 1'b0, '0);
        chk("uflow_err",  32'(ERR),  32'd1);
        chk("uflow_busy", 32'(BUSY), 32'd0);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < DEP; i++) begin
            tick(1'b0, 1'b1, 1'b0, DW'($urandom), 1'b0, '0);
            idle();
        end
        chk("fill_full", 32'(FULL), 32'd1);
        tick(1'b0, 1'b1, 1'b0, 10'h3FF, 1'b0, '0);
        chk("oflow_err", 32'(ERR),    32'd1);
        chk("oflow_we",  32'(SCR_WE), 32'd0);

        // Simultaneous PUSH and POP rejected; PUSH during pop ignored.
        tick(1'b0, 1'b1, 1'b1, '0, 1'b0, '0);
        chk("both_err", 32'(ERR), 32'd1);
        tick(1'b0, 1'b0, 1'b1, '0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, 10'h111, 1'b0, '0);
        chk("ign_we", 32'(SCR_WE), 32'd0);
        idle();
        chk("ign_done", 32'(DONE), 32'd1);
        idle();
        chk("ign_busy", 32'(BUSY), 32'd0);

        // SP load empties a three-deep stack.
        tick(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'h40);
        chk("ld_empty", 32'(EMPTY), 32'd1);

        // Reset during POP_RD abandons the pop.
        tick(1'b0, 1'b1, 1'b0, 10'h0AA, 1'b0, '0);
        idle();
        tick(1'b0, 1'b0, 1'b1, '0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("rstop_incr", 32'(SP_INCR),  32'd0);
        chk("rstop_done", 32'(DONE),     32'd0);
        chk("rstop_pop",  32'(POP_DATA), 32'd0);
        chk("rstop_sp",   32'(sp),       32'h03F);
        idle();
        chk("rstop_busy", 32'(BUSY), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 63) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 DW'($urandom),
                 $urandom_range(0, 31) == 0,
                 AW'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
